encoder_8x3_seq: RTL and testbench

Sequential 8-to-3 encoder, the inverse of the 3x8 decoder in the circuits library. It accepts an 8-bit multi-hot request vector over a valid/ready handshake. It then emits the 3-bit index of every set bit, one index per accepted output beat, in a fixed priority order, and flags the final index of each vector. It sits between any multi-hot status or request source and consumers that expect one binary index at a time.

---
 rtl/encoder_8x3_seq.sv | 106 ++++++++++
 tb/tb_encoder_8x3_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector and emits the index
// of each set bit, one per output beat, in a fixed priority order.
module encoder_8x3_seq #(
    parameter bit PRIORITY_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out,
    output logic       out_last,
    output logic       zero_in
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       zero_in_q, zero_in_d;

    logic [2:0] sel_idx;
    logic       sel_found;
    logic [7:0] sel_onehot;
    logic       single_bit;

    // Priority pick over pending; direction fixed at elaboration.
    always_comb begin
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        if (PRIORITY_LOW) begin
            for (int i = 0; i < 8; i++) begin
                if (!sel_found && pending_q[i]) begin
                    sel_idx   = 3'(i);
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (!sel_found && pending_q[i]) begin
                    sel_idx   = 3'(i);
                    sel_found = 1'b1;
                end
            end
        end
    end

    assign sel_onehot = 8'd1 << sel_idx;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign single_bit = (pending_q != 8'd0) && ((pending_q & (pending_q - 8'd1)) == 8'd0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_in_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d = in_vec;
                    if (in_vec != 8'd0) begin
                        state_d = BUSY;
                    end else begin
                        zero_in_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pending_d = pending_q & ~sel_onehot;
                    if (single_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            zero_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_in_q <= zero_in_d;
        end
    end

    // Handshake flags depend on state only; index outputs are masked when idle.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == BUSY);
    assign out       = out_valid ? sel_idx : 3'd0;
    assign out_last  = out_valid & single_bit;
    assign zero_in   = zero_in_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Bench for encoder_8x3_seq: one instance per priority direction, directed
// vectors with hand-computed expected index streams checked by monitors.
module tb_encoder_8x3_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Valid/ready: a beat transfers on a rising edge where valid and ready are
    // both high; the sender holds its payload stable until that edge.
    logic       in_valid_lo = 1'b0, in_valid_hi = 1'b0;
    logic [7:0] in_vec_lo = 8'd0, in_vec_hi = 8'd0;
    logic       out_ready_lo = 1'b1, out_ready_hi = 1'b1;
    logic       in_ready_lo, in_ready_hi;
    logic       out_valid_lo, out_valid_hi;
    logic [2:0] out_lo, out_hi;
    logic       out_last_lo, out_last_hi;
    logic       zero_in_lo, zero_in_hi;

    encoder_8x3_seq #(.PRIORITY_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_lo), .in_ready(in_ready_lo), .in_vec(in_vec_lo),
        .out_valid(out_valid_lo), .out_ready(out_ready_lo),
        .out(out_lo), .out_last(out_last_lo), .zero_in(zero_in_lo)
    );

    encoder_8x3_seq #(.PRIORITY_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_hi), .in_ready(in_ready_hi), .in_vec(in_vec_hi),
        .out_valid(out_valid_hi), .out_ready(out_ready_hi),
        .out(out_hi), .out_last(out_last_hi), .zero_in(zero_in_hi)
    );

    // Scoreboard entries are {last, index}.
    logic [3:0] exp_lo_q[$];
    logic [3:0] exp_hi_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit hi, input logic [2:0] idx, input logic last);
        if (hi) exp_hi_q.push_back({last, idx});
        else    exp_lo_q.push_back({last, idx});
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_lo) begin
                if (out_ready_lo) begin
                    if (exp_lo_q.size() == 0) begin
                        check("lo_unexpected_beat", {4'd0, out_last_lo, out_lo}, 8'hEE);
                    end else begin
                        check("lo_beat", {4'd0, out_last_lo, out_lo}, {4'd0, exp_lo_q.pop_front()});
                    end
                end
            end else begin
                check("lo_idle_out", {4'd0, out_last_lo, out_lo}, 8'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_hi) begin
                if (out_ready_hi) begin
                    if (exp_hi_q.size() == 0) begin
                        check("hi_unexpected_beat", {4'd0, out_last_hi, out_hi}, 8'hEE);
                    end else begin
                        check("hi_beat", {4'd0, out_last_hi, out_hi}, {4'd0, exp_hi_q.pop_front()});
                    end
                end
            end else begin
                check("hi_idle_out", {4'd0, out_last_hi, out_hi}, 8'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a vector and return one step after the accepting edge.
    task automatic accept(input bit hi, input logic [7:0] vec);
        int t = 0;
        while (!(hi ? in_ready_hi : in_ready_lo) && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) check("accept_timeout", 8'd1, 8'd0);
        if (hi) begin in_valid_hi = 1'b1; in_vec_hi = vec; end
        else    begin in_valid_lo = 1'b1; in_vec_lo = vec; end
        step();
        in_valid_lo = 1'b0; in_vec_lo = 8'd0;
        in_valid_hi = 1'b0; in_vec_hi = 8'd0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_lo_q.size() != 0 || exp_hi_q.size() != 0 || !in_ready_lo || !in_ready_hi) && t < 60) begin
            step();
            t++;
        end
        if (t >= 60) check("drain_timeout", 8'd1, 8'd0);
    endtask

    initial begin
        #2;
        check("rst_in_ready",  {7'd0, in_ready_lo},  8'd1);
        check("rst_out_valid", {7'd0, out_valid_lo}, 8'd0);
        check("rst_out",       {5'd0, out_lo},       8'd0);
        check("rst_out_last",  {7'd0, out_last_lo},  8'd0);
        check("rst_zero_in",   {7'd0, zero_in_lo},   8'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Basic emission: 1010_0100 -> 2,5,7; in_ready back after three beats.
        push(0, 3'd2, 1'b0); push(0, 3'd5, 1'b0); push(0, 3'd7, 1'b1);
        accept(0, 8'b1010_0100);
        for (int i = 0; i < 3; i++) begin
            check("basic_busy_in_ready", {7'd0, in_ready_lo}, 8'd0);
            step();
        end
        check("basic_in_ready_back", {7'd0, in_ready_lo}, 8'd1);
        drain();

        // Backpressure: index 2 held stable for three stalled cycles.
        out_ready_lo = 1'b0;
        push(0, 3'd2, 1'b0); push(0, 3'd5, 1'b0); push(0, 3'd7, 1'b1);
        accept(0, 8'b1010_0100);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", {7'd0, out_valid_lo}, 8'd1);
            check("bp_out",       {5'd0, out_lo},       8'd2);
            check("bp_out_last",  {7'd0, out_last_lo},  8'd0);
            step();
        end
        out_ready_lo = 1'b1;
        drain();

        // Zero vector, then 8'h01 accepted on the very next cycle.
        accept(0, 8'h00);
        check("zero_pulse",    {7'd0, zero_in_lo},  8'd1);
        check("zero_in_ready", {7'd0, in_ready_lo}, 8'd1);
        push(0, 3'd0, 1'b1);
        in_valid_lo = 1'b1; in_vec_lo = 8'h01;
        step();
        in_valid_lo = 1'b0; in_vec_lo = 8'h00;
        check("zero_pulse_end", {7'd0, zero_in_lo},   8'd0);
        check("after_zero_out", {4'd0, out_last_lo, out_lo}, 8'h08);
        drain();

        // High-first priority over a full vector.
        for (int i = 7; i >= 0; i--) push(1, 3'(i), (i == 0));
        accept(1, 8'hFF);
        drain();

        // Input held through BUSY: 8'h10 only taken once idle again.
        push(0, 3'd0, 1'b0); push(0, 3'd7, 1'b1); push(0, 3'd4, 1'b1);
        accept(0, 8'h81);
        in_valid_lo = 1'b1; in_vec_lo = 8'h10;
        check("held_busy0", {7'd0, in_ready_lo}, 8'd0);
        step();
        check("held_busy1", {7'd0, in_ready_lo}, 8'd0);
        step();
        check("held_idle", {7'd0, in_ready_lo}, 8'd1);
        step();
        in_valid_lo = 1'b0; in_vec_lo = 8'h00;
        drain();

        // Reset mid-burst after index 4 is consumed.
        push(0, 3'd4, 1'b0);
        accept(0, 8'hF0);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {7'd0, out_valid_lo}, 8'd0);
        check("mid_rst_out",       {5'd0, out_lo},       8'd0);
        check("mid_rst_in_ready",  {7'd0, in_ready_lo},  8'd1);
        check("mid_rst_queue",     8'(exp_lo_q.size()),  8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();
        push(0, 3'd1, 1'b1);
        accept(0, 8'h02);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
